// File: rtl/cube_move_ctrl.sv
// Cube move sequencer: turns one start press into quarter-turn requests for the
// rotation datapath, and keeps a BCD count of completed moves for the HEX display.

module cube_bcd_digit (
  input  logic       cin,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       cout
);
  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (d == 4'd9) begin
        q    = 4'd0;
        cout = 1'b1;
      end else begin
        q = d + 4'd1;
      end
    end
  end
endmodule

module cube_move_ctrl #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int TO_W        = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  face_in,
  input  logic [1:0]  rot_ctrl,
  output logic        rot_req,
  output logic [2:0]  rot_face,
  output logic        rot_dir,
  input  logic        rot_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] move_bcd,
  output logic [3:0]  state,
  output logic [1:0]  disp_mode
);
  localparam int NUM_DIGITS = 4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHECK = 4'd1,
    S_ISSUE = 4'd2,
    S_WAIT  = 4'd3,
    S_DONE  = 4'd4,
    S_ERR   = 4'd5
  } state_t;

  state_t cur, nxt;

  logic                             start_q;
  logic [5:0]                       face_q;
  logic [1:0]                       ctrl_q;
  logic [1:0]                       turns;
  logic [TO_W-1:0]                  to_cnt;
  logic [NUM_DIGITS-1:0][3:0]       bcd, bcd_inc;
  logic [NUM_DIGITS:0]              carry;

  logic accept, face_ok, move_ok, ack_hit, to_hit;

  function automatic logic [2:0] enc_face(input logic [5:0] f);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 6; i++)
      if (f[i]) r = 3'(i);
    return r;
  endfunction

  assign accept  = start & ~start_q & (cur == S_IDLE);
  assign face_ok = (face_q != 6'd0) && ((face_q & (face_q - 6'd1)) == 6'd0);
  assign move_ok = face_ok && (ctrl_q != 2'd3);
  // Acks are only meaningful while a request is outstanding.
  assign ack_hit = rot_ack & rot_req;
  assign to_hit  = (to_cnt == TO_W'(ACK_TIMEOUT - 1));

  // Ripple-carry BCD increment; carry out of the top digit is dropped so 9999 wraps.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    cube_bcd_digit u_digit (
      .cin  (carry[g]),
      .d    (bcd[g]),
      .q    (bcd_inc[g]),
      .cout (carry[g+1])
    );
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:  if (accept) nxt = S_CHECK;
      S_CHECK: nxt = move_ok ? S_ISSUE : S_ERR;
      S_ISSUE: nxt = S_WAIT;
      S_WAIT: begin
        if (ack_hit)     nxt = (turns == 2'd1) ? S_DONE : S_ISSUE;
        else if (to_hit) nxt = S_ERR;
      end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b1;
      face_q   <= 6'd0;
      ctrl_q   <= 2'd0;
      turns    <= 2'd0;
      to_cnt   <= '0;
      rot_req  <= 1'b0;
      rot_face <= 3'd0;
      rot_dir  <= 1'b0;
      err      <= 1'b0;
      bcd      <= '0;
    end else begin
      start_q <= start;
      case (cur)
        S_IDLE: begin
          if (accept) begin
            face_q <= face_in;
            ctrl_q <= rot_ctrl;
          end
        end
        S_CHECK: begin
          if (move_ok) begin
            err      <= 1'b0;
            turns    <= (ctrl_q == 2'd2) ? 2'd2 : 2'd1;
            rot_dir  <= (ctrl_q == 2'd1);
            rot_face <= enc_face(face_q);
          end
        end
        S_ISSUE: begin
          rot_req <= 1'b1;
          to_cnt  <= '0;
        end
        S_WAIT: begin
          if (ack_hit) begin
            rot_req <= 1'b0;
            turns   <= turns - 2'd1;
          end else if (to_hit) begin
            rot_req <= 1'b0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_DONE:  bcd <= bcd_inc;
        S_ERR:   err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign state     = cur;
  assign busy      = (cur != S_IDLE);
  assign done      = (cur == S_DONE);
  assign move_bcd  = bcd;
  assign disp_mode = err ? 2'd2 : (busy ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_cube_move_ctrl.sv
// Scoreboard bench for cube_move_ctrl: expected requests/done/error events are
// queued from a move-level model and popped by a monitor as the DUT produces them.

module tb_cube_move_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, rot_ack = 1'b0;
  logic [5:0]  face_in = 6'd0;
  logic [1:0]  rot_ctrl = 2'd0;
  logic        rot_req, rot_dir, busy, done, err;
  logic [2:0]  rot_face;
  logic [15:0] move_bcd;
  logic [3:0]  state;
  logic [1:0]  disp_mode;

  cube_move_ctrl #(.ACK_TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .face_in(face_in), .rot_ctrl(rot_ctrl),
    .rot_req(rot_req), .rot_face(rot_face), .rot_dir(rot_dir), .rot_ack(rot_ack),
    .busy(busy), .done(done), .err(err), .move_bcd(move_bcd), .state(state),
    .disp_mode(disp_mode)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int face; int dir; int val; } ev_t;  // kind: 0 req, 1 done, 2 err
  ev_t sbq[$];

  int checks = 0, failures = 0;
  int model_cnt = 0;
  bit model_err = 1'b0;
  int cyc = 0, edge_cyc = 0, done_cyc = -1, req_hi = 0;
  int ack_mode = 0, fix_delay = 0;  // 0 random+junk, 1 fixed delay, 2 never ack

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int to_bcd(input int n);
    return (((n / 1000) % 10) << 12) | (((n / 100) % 10) << 8) |
           (((n / 10) % 10) << 4) | (n % 10);
  endfunction

  task automatic pop_ev(input int kind, output ev_t e);
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_underflow actual_kind=%0d required=none", kind);
      e = '{kind: -1, face: -1, dir: -1, val: -1};
    end else begin
      e = sbq.pop_front();
      chk("event_kind", kind, e.kind);
    end
  endtask

  // Datapath model: acks after a delay, optionally toggling junk acks while idle.
  int wcnt = 0, dly = 0;
  always @(negedge clk) begin
    if (rot_req) begin
      if (ack_mode == 2) rot_ack = 1'b0;
      else if (wcnt >= dly) rot_ack = 1'b1;
      else begin rot_ack = 1'b0; wcnt++; end
    end else begin
      rot_ack = (ack_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      wcnt = 0;
      dly = (ack_mode == 1) ? fix_delay : int'($urandom_range(0, 3));
    end
  end

  // Monitor
  logic prev_req = 1'b0;
  logic [3:0] prev_state = 4'd0;
  int hold_face = 0, hold_dir = 0;
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      prev_req = 1'b0;
      prev_state = 4'd0;
    end else begin
      chk("busy", int'(busy), int'(state != 4'd0));
      if (rot_req) req_hi++;
      if (rot_req && !prev_req) begin
        pop_ev(0, e);
        chk("rot_face", int'(rot_face), e.face);
        chk("rot_dir", int'(rot_dir), e.dir);
        hold_face = int'(rot_face);
        hold_dir = int'(rot_dir);
      end else if (rot_req) begin
        chk("rot_face_stable", int'(rot_face), hold_face);
        chk("rot_dir_stable", int'(rot_dir), hold_dir);
      end
      if (done) begin
        done_cyc = cyc;
        pop_ev(1, e);
        chk("bcd_at_done", int'(move_bcd), e.val);
      end
      if (state == 4'd5 && prev_state != 4'd5) begin
        pop_ev(2, e);
        chk("state_before_err", int'(prev_state), e.face);
      end
      prev_req = rot_req;
      prev_state = state;
    end
  end

  // Caller must be at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_move(input logic [5:0] f, input logic [1:0] rc, input bit retrig, input bit tmo);
    int n, idx, b;
    bit valid;
    valid = ($countones(f) == 1) && (rc != 2'd3);
    idx = 0;
    for (int i = 0; i < 6; i++) if (f[i]) idx = i;
    if (!valid) begin
      sbq.push_back('{kind: 2, face: 1, dir: 0, val: 0});
      model_err = 1'b1;
    end else if (tmo) begin
      sbq.push_back('{kind: 0, face: idx, dir: int'(rc == 2'd1), val: 0});
      sbq.push_back('{kind: 2, face: 3, dir: 0, val: 0});
      model_err = 1'b1;
    end else begin
      n = (rc == 2'd2) ? 2 : 1;
      for (int k = 0; k < n; k++)
        sbq.push_back('{kind: 0, face: idx, dir: int'(rc == 2'd1), val: 0});
      sbq.push_back('{kind: 1, face: 0, dir: 0, val: to_bcd(model_cnt)});
      model_cnt = (model_cnt + 1) % 10000;
      model_err = 1'b0;
    end
    face_in = f;
    rot_ctrl = rc;
    start = 1'b1;
    edge_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    face_in = 6'($urandom);
    rot_ctrl = 2'($urandom);
    if (retrig) begin
      b = 0;
      while (state != 4'd3 && b < 50) begin @(negedge clk); b++; end
      chk("reach_wait", int'(b < 50), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    b = 0;
    while (state != 4'd0 && b < 200) begin @(negedge clk); b++; end
    chk("move_finish", int'(b < 200), 1);
    chk("move_bcd", int'(move_bcd), to_bcd(model_cnt));
    chk("err", int'(err), int'(model_err));
    chk("disp_mode", int'(disp_mode), model_err ? 2 : 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, b;
    logic [5:0] f;
    // Reset with start held high: the held level must not count as an edge.
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_rot_req", int'(rot_req), 0);
    chk("rst_move_bcd", int'(move_bcd), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_disp_mode", int'(disp_mode), 0);
    start = 1'b0;
    @(negedge clk);

    ack_mode = 1; fix_delay = 2;
    do_move(6'b000100, 2'd0, 0, 0);
    fix_delay = 0;
    do_move(6'b010000, 2'd1, 0, 0);
    chk("latency_done", done_cyc - edge_cyc, 4);
    fix_delay = 1;
    do_move(6'b100000, 2'd2, 0, 0);

    do_move(6'b000011, 2'd0, 0, 0);
    do_move(6'b000100, 2'd3, 0, 0);
    do_move(6'b000000, 2'd1, 0, 0);
    do_move(6'b001000, 2'd1, 0, 0);

    ack_mode = 0;
    for (int i = 0; i < 150; i++) begin
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
      do_move(f, 2'($urandom_range(0, 3)), 0, 0);
    end

    ack_mode = 1; fix_delay = 3;
    do_move(6'b000001, 2'd0, 1, 0);
    repeat (3) @(negedge clk);
    chk("retrig_idle", int'(state), 0);

    ack_mode = 2;
    r0 = req_hi;
    do_move(6'b000010, 2'd1, 0, 1);
    chk("timeout_req_cycles", req_hi - r0, TO);
    chk("timeout_busy", int'(busy), 0);

    // Reset while waiting on an ack; make sure the count is nonzero first.
    ack_mode = 1; fix_delay = 0;
    do_move(6'b000001, 2'd0, 0, 0);
    ack_mode = 2;
    sbq.push_back('{kind: 0, face: 1, dir: 0, val: 0});
    face_in = 6'b000010;
    rot_ctrl = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b = 0;
    while (!rot_req && b < 20) begin @(negedge clk); b++; end
    chk("mid_wait_req", int'(rot_req), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rot_req", int'(rot_req), 0);
    chk("midrst_move_bcd", int'(move_bcd), 0);
    chk("midrst_state", int'(state), 0);
    rst = 1'b0;
    sbq.delete();
    model_cnt = 0;
    model_err = 1'b0;
    @(negedge clk);

    // Roll the counter through 9999 back to 0000.
    ack_mode = 1; fix_delay = 0;
    for (int i = 0; i < 10000; i++)
      do_move(6'(1 << $urandom_range(0, 5)), 2'($urandom_range(0, 1)), 0, 0);
    chk("wrap_bcd", int'(move_bcd), 16'h0000);

    repeat (3) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
